// File: rtl/shift_arbiter_sequencer_pkg.sv
// Shared types and defaults for the round-robin multi-cycle shift sequencer.
package shift_arbiter_sequencer_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned AMT_W            = 5;
    localparam int unsigned MAX_STEP_DEFAULT = 4;
    localparam int unsigned ID_W_MAX         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_seq_state_t;

    // The id field is sized for the widest supported ID_W; narrower ids are zero-extended.
    typedef struct packed {
        logic [DATA_W-1:0]   operand;
        logic [AMT_W-1:0]    amount;
        logic                arith;
        logic                lshift;
        logic [ID_W_MAX-1:0] id;
    } shift_req_t;

endpackage

// File: rtl/shift_arbiter_sequencer_shift_step.sv
// Stateless single-step shifter: moves a 32-bit word by 0..MAX_STEP bits in either direction.
module shift_arbiter_sequencer_shift_step
    import shift_arbiter_sequencer_pkg::*;
#(
    parameter int unsigned MAX_STEP = MAX_STEP_DEFAULT,
    parameter int unsigned STEP_W   = $clog2(MAX_STEP + 1)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [STEP_W-1:0] amount,
    input  logic              lshift,
    input  logic              fill,
    output logic [DATA_W-1:0] result
);

    logic [2*DATA_W-1:0] ext;

    assign ext = {{DATA_W{fill}}, data};

    always_comb begin
        result = data;
        for (int unsigned k = 1; k <= MAX_STEP; k++) begin
            if (amount == STEP_W'(k)) begin
                result = lshift ? (data << k) : DATA_W'(ext >> k);
            end
        end
    end

endmodule

// File: rtl/shift_arbiter_sequencer.sv
// Round-robin arbiter sharing one iterative shifter; result held on a valid/ack handshake.
module shift_arbiter_sequencer
    import shift_arbiter_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned MAX_STEP = MAX_STEP_DEFAULT,
    parameter int unsigned ID_W     = 3
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_REQ-1:0]                              req,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]                  req_operand,
    input  logic [NUM_REQ-1:0][AMT_W-1:0]                   req_amount,
    input  logic [NUM_REQ-1:0]                              req_arith,
    input  logic [NUM_REQ-1:0]                              req_lshift,
    input  logic [NUM_REQ-1:0][ID_W-1:0]                    req_id,
    output logic [NUM_REQ-1:0]                              grant,
    output logic                                            busy,
    output logic                                            result_valid,
    input  logic                                            result_ack,
    output logic [DATA_W-1:0]                               result,
    output logic [ID_W-1:0]                                 result_id,
    output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0]  result_port
);

    localparam int unsigned PORT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STEP_W = $clog2(MAX_STEP + 1);

    shift_seq_state_t  state;
    shift_req_t        cur;
    logic [PORT_W-1:0] ptr;
    logic [PORT_W-1:0] port_q;

    logic              any_req;
    logic [PORT_W-1:0] sel;
    logic [PORT_W-1:0] ptr_next;
    logic [STEP_W-1:0] step_amt;
    logic [DATA_W-1:0] step_out;

    // Round-robin pick: first requester at or after ptr, wrapping.
    always_comb begin
        int unsigned idx;
        any_req = 1'b0;
        sel     = '0;
        idx     = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr) + off) % NUM_REQ;
            if (!any_req && ((req & (NUM_REQ'(1) << idx)) != '0)) begin
                any_req = 1'b1;
                sel     = PORT_W'(idx);
            end
        end
    end

    assign ptr_next = (32'(sel) == NUM_REQ - 1) ? '0 : sel + PORT_W'(1);

    // Grant is asserted in the capture cycle itself so the requester can drop req right after.
    assign grant = (state == IDLE && any_req) ? (NUM_REQ'(1) << sel) : '0;

    assign step_amt = (cur.amount > AMT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : STEP_W'(cur.amount);

    shift_arbiter_sequencer_shift_step #(
        .MAX_STEP (MAX_STEP),
        .STEP_W   (STEP_W)
    ) u_step (
        .data   (cur.operand),
        .amount (step_amt),
        .lshift (cur.lshift),
        .fill   (cur.arith),
        .result (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cur    <= '0;
            ptr    <= '0;
            port_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        cur.operand <= req_operand[sel];
                        cur.amount  <= req_amount[sel];
                        cur.arith   <= req_arith[sel];
                        cur.lshift  <= req_lshift[sel];
                        cur.id      <= ID_W_MAX'(req_id[sel]);
                        port_q      <= sel;
                        ptr         <= ptr_next;
                        state       <= (req_amount[sel] == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    cur.operand <= step_out;
                    cur.amount  <= cur.amount - AMT_W'(step_amt);
                    if (cur.amount == AMT_W'(step_amt)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign result       = cur.operand;
    assign result_id    = cur.id[ID_W-1:0];
    assign result_port  = port_q;

endmodule
